// File: rtl/core_muldiv_pkg.sv
// rtl/core_muldiv_pkg.sv - opcode constants, FSM states and helpers for core_muldiv_unit
package core_muldiv_pkg;

    // bit 2: divide class; for divides bit 1: unsigned, bit 0: remainder
    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULH  = 3'b001;
    localparam logic [2:0] OP_MULHU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_MOD   = 3'b101;
    localparam logic [2:0] OP_DIVU  = 3'b110;
    localparam logic [2:0] OP_MODU  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/core_muldiv_if.sv
// rtl/core_muldiv_if.sv - request/result handshake bundle of core_muldiv_unit
interface core_muldiv_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  op_i;
    logic [31:0] r1_i;
    logic [31:0] r0_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_o;

    modport master (
        output req_valid_i, op_i, r1_i, r0_i, res_ready_i,
        input  req_ready_o, res_valid_o, res_o
    );

    modport slave (
        input  req_valid_i, op_i, r1_i, r0_i, res_ready_i,
        output req_ready_o, res_valid_o, res_o
    );
endinterface

// File: rtl/core_div_iter.sv
// rtl/core_div_iter.sv - one radix-2 restoring division step; built only with CORE_MULDIV_DIV_EN
`ifdef CORE_MULDIV_DIV_EN
module core_div_iter (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] div_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);
    logic [32:0] shifted;
    logic [31:0] sub;
    logic        ge;

    // quo_i holds unconsumed dividend bits at the top and quotient bits at the bottom
    always_comb begin
        shifted = {rem_i, quo_i[31]};
        ge      = shifted >= {1'b0, div_i};
        sub     = shifted[31:0] - div_i;
        rem_o   = ge ? sub : shifted[31:0];
        quo_o   = {quo_i[30:0], ge};
    end
endmodule
`endif

// File: rtl/core_muldiv_unit.sv
// rtl/core_muldiv_unit.sv - LA32R multi-cycle multiply/divide unit; divider present only with CORE_MULDIV_DIV_EN
module core_muldiv_unit
    import core_muldiv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    core_muldiv_if.slave  bus
);
    state_e      state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q, res_q;
    logic        accept;
    logic        mul_sx;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] mul_res;

    assign accept          = bus.req_valid_i && (state_q == ST_IDLE) && !flush_i;
    assign bus.req_ready_o = (state_q == ST_IDLE);
    assign bus.res_valid_o = (state_q == ST_DONE);
    assign bus.res_o       = res_q;

    // 33x33 signed product of sign/zero-extended operands, widened to 64 bits
    always_comb begin
        mul_sx  = (op_q != OP_MULHU);
        mul_a   = {{32{mul_sx & a_q[31]}}, a_q};
        mul_b   = {{32{mul_sx & b_q[31]}}, b_q};
        prod    = mul_a * mul_b;
        mul_res = '0;
        case (op_q)
            OP_MUL:           mul_res = prod[31:0];
            OP_MULH, OP_MULHU: mul_res = prod[63:32];
            default:          mul_res = '0;
        endcase
    end

`ifdef CORE_MULDIV_DIV_EN
    logic [31:0] rem_q, quo_q, dvs_q;
    logic [31:0] rem_nx, quo_nx;
    logic [31:0] abs_a, abs_b;
    logic [4:0]  cnt_q;
    logic        load_q;
    logic        sgn_div, q_neg, r_neg;

    always_comb begin
        sgn_div = !op_q[1];
        q_neg   = sgn_div & (a_q[31] ^ b_q[31]);
        r_neg   = sgn_div & a_q[31];
        abs_a   = neg_if(a_q, sgn_div & a_q[31]);
        abs_b   = neg_if(b_q, sgn_div & b_q[31]);
    end

    core_div_iter u_div_iter (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
`ifdef CORE_MULDIV_DIV_EN
                    if (!bus.op_i[2])           state_d = ST_MUL;
                    else if (bus.r0_i == 32'd0) state_d = ST_DONE;
                    else                        state_d = ST_DIV;
`else
                    state_d = ST_MUL;
`endif
                end
                ST_MUL:  state_d = ST_DONE;
`ifdef CORE_MULDIV_DIV_EN
                ST_DIV:  if (!load_q && cnt_q == 5'd31) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
`endif
                ST_DONE: if (bus.res_ready_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // first DIV cycle converts the registered operands to magnitudes, then 32 steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_MUL;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
`ifdef CORE_MULDIV_DIV_EN
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            load_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q <= bus.op_i;
                a_q  <= bus.r1_i;
                b_q  <= bus.r0_i;
`ifdef CORE_MULDIV_DIV_EN
                load_q <= 1'b1;
                cnt_q  <= '0;
                if (bus.op_i[2] && bus.r0_i == 32'd0)
                    res_q <= bus.op_i[0] ? bus.r1_i : 32'hFFFF_FFFF;
`endif
            end
            case (state_q)
                ST_MUL: res_q <= mul_res;
`ifdef CORE_MULDIV_DIV_EN
                ST_DIV: begin
                    if (load_q) begin
                        rem_q  <= '0;
                        quo_q  <= abs_a;
                        dvs_q  <= abs_b;
                        load_q <= 1'b0;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_FIX: res_q <= op_q[0] ? neg_if(rem_q, r_neg) : neg_if(quo_q, q_neg);
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_muldiv_unit.sv
// tb/tb_core_muldiv_unit.sv - scoreboard bench for core_muldiv_unit (follows CORE_MULDIV_DIV_EN)
module tb_core_muldiv_unit;

    logic clk;
    logic rst_n;
    logic flush_i;

    core_muldiv_if bus ();

    core_muldiv_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_en;
        logic [31:0] exp_dis;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   seen  = 0;
    bit   rand_rr = 0;
    logic [2:0] ops_tab [7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: plain integer arithmetic on the architectural definitions
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb_;
        longint sp;
        longint unsigned up;
        sa  = a;
        sb_ = b;
        sp  = longint'(sa) * longint'(sb_);
        up  = {32'd0, a} * {32'd0, b};
        case (op)
            3'b000: return sp[31:0];
            3'b001: return sp[63:32];
            3'b010: return up[63:32];
            default: ;
        endcase
`ifdef CORE_MULDIV_DIV_EN
        if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
        if (op[1]) return op[0] ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'd0 : 32'h8000_0000;
        return op[0] ? 32'(sa % sb_) : 32'(sa / sb_);
`else
        return 32'd0;
`endif
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] b);
`ifdef CORE_MULDIV_DIV_EN
        if (!op[2]) return 2;
        return (b == 32'd0) ? 1 : 35;
`else
        return 2;
`endif
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // called at posedge+#1; returns at posedge+#1 after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
        int  n = 0;
        bit  took = 0;
        bus.req_valid_i = 1'b1;
        bus.op_i = op;
        bus.r1_i = a;
        bus.r0_i = b;
        while (!took && n < 300) begin
            @(negedge clk);
            took = bus.req_ready_o && !flush_i && rst_n;
            @(posedge clk);
            #1;
            n++;
        end
        bus.req_valid_i = 1'b0;
        bus.op_i = $urandom;
        bus.r1_i = $urandom;
        bus.r0_i = $urandom;
        if (!took) chk("accept_timeout", 32'd0, 32'd1);
        else sb.push_back('{res: exp_res, lat: exp_lat, acc: cyc});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
            seen = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.res_valid_o) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(bus.res_valid_o), 32'd0);
            end else begin
                chk("req_ready_while_valid", 32'(bus.req_ready_o), 32'd0);
                if (!seen) begin
                    chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                    chk("result", bus.res_o, sb[0].res);
                    seen = 1;
                end else begin
                    chk("hold_stable", bus.res_o, sb[0].res);
                end
                if (bus.res_ready_i) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rr) bus.res_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, e;
        bit          any_valid;
        int          n;

        ops_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
        vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFEB});
        vecs.push_back('{3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{3'b010, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 32'h0000_0006});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'h0000_0000});
        vecs.push_back('{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0000});
        vecs.push_back('{3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{3'b101, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000});
        vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{3'b100, 32'd10,        32'd3,        32'd3,        32'h0000_0000});
        vecs.push_back('{3'b000, 32'd10,        32'd3,        32'd30,       32'd30});

        rst_n = 1'b0;
        flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.op_i = '0;
        bus.r1_i = '0;
        bus.r0_i = '0;
        bus.res_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready_o), 32'd1);
        chk("reset_res_valid", 32'(bus.res_valid_o), 32'd0);
        chk("reset_res", bus.res_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
`ifdef CORE_MULDIV_DIV_EN
            e = vecs[i].exp_en;
`else
            e = vecs[i].exp_dis;
`endif
            issue(vecs[i].op, vecs[i].a, vecs[i].b, e, lat_of(vecs[i].op, vecs[i].b));
        end
        drain();

        // backpressure: result held while the consumer stalls
        bus.res_ready_i = 1'b0;
        issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        n = 0;
        while (!bus.res_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("stall_res_valid", 32'(bus.res_valid_o), 32'd1);
        @(posedge clk);
        #1;
        bus.res_ready_i = 1'b1;
        drain();

        // flush during a division
        issue(3'b100, 32'd1000, 32'd7, ref_res(3'b100, 32'd1000, 32'd7), lat_of(3'b100, 32'd7));
        repeat (11) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        sb.delete();
        seen = 0;
        @(negedge clk);
        chk("flush_req_ready", 32'(bus.req_ready_o), 32'd1);
        any_valid = 0;
        repeat (40) begin
            any_valid |= bus.res_valid_o;
            @(negedge clk);
        end
        chk("flush_no_valid", 32'(any_valid), 32'd0);
        @(posedge clk);
        #1;
        issue(3'b000, 32'd10, 32'd3, 32'd30, 2);
        drain();

        // randomized traffic with random consumer backpressure
        rand_rr = 1;
        repeat (60) begin
            op = ops_tab[$urandom_range(0, 6)];
            a = rnd_operand();
            b = rnd_operand();
            issue(op, a, b, ref_res(op, a, b), lat_of(op, b));
        end
        drain();
        rand_rr = 0;
        bus.res_ready_i = 1'b1;

        // reset in the middle of an operation
        issue(3'b101, 32'hFFFF_FC18, 32'd7, ref_res(3'b101, 32'hFFFF_FC18, 32'd7), lat_of(3'b101, 32'd7));
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_req_ready", 32'(bus.req_ready_o), 32'd1);
        chk("midreset_res_valid", 32'(bus.res_valid_o), 32'd0);
        chk("midreset_res", bus.res_o, 32'd0);
        sb.delete();
        seen = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/core_muldiv_unit.md
# core_muldiv_unit

Multi-cycle integer multiply/divide unit for the LA32R execute stage. Accepts two 32-bit operands and an opcode through a valid/ready handshake, computes MUL.W / MULH.W / MULH.WU / DIV.W / MOD.W / DIV.WU / MOD.WU, and holds the 32-bit result until the consumer takes it. Its result port is the producer side of the ALU's multiplier-result input (`mul_i`), which the ALU selects in its INT group.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: unit can accept; high only in IDLE.
- `op_i` in 3: opcode (encodings in package).
- `r1_i` in 32: first operand (rj; dividend / multiplicand).
- `r0_i` in 32: second operand (rk; divisor / multiplier).
- `flush_i` in 1: pipeline flush; kills any in-flight operation.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: consumer takes result.
- `res_o` out 32: result; feeds ALU `mul_i`.

## Operation
- Request accepted on a rising edge where `req_valid_i && req_ready_o && !flush_i`; operands and opcode are registered, then inputs are ignored.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL on accepted multiply op; -> DIV on accepted divide op with nonzero divisor; -> DONE on divide with divisor zero.
  - MUL -> DONE after 1 cycle (33x33 signed product of sign/zero-extended operands).
  - DIV: radix-2 restoring, one quotient bit per cycle on absolute values, 32 cycles, iteration counter 0..31; -> FIX at count 31.
  - FIX: apply signs; -> DONE.
  - DONE: `res_valid_o` high; -> IDLE on `res_ready_i`.
  - Any state -> IDLE on `flush_i`; flush has priority over acceptance and completion.
- Results: MUL.W = product[31:0]; MULH.W = signed product[63:32]; MULH.WU = unsigned product[63:32].
- Signed division truncates toward zero; remainder carries the dividend's sign.
- Divide-by-zero: quotient = 0xFFFF_FFFF, remainder = dividend (signed and unsigned).
- Overflow 0x8000_0000 / 0xFFFF_FFFF signed: quotient = 0x8000_0000, remainder = 0; falls out of the normal datapath, no special state.
- `res_o` is stable and unchanged for the whole time `res_valid_o` is high.

## Timing
- Reset: state IDLE, `req_ready_o` = 1, `res_valid_o` = 0, `res_o` = 0, counter = 0.
- Accept at edge T: multiply -> `res_valid_o` from T+2; divide -> from T+35 (32 DIV + FIX + DONE); divide-by-zero -> from T+1.
- `req_ready_o` is registered state decode only, no combinational path from `res_ready_i`; a new request is accepted at the earliest one cycle after the result handshake.
- Flush in cycle C: `res_valid_o` low and `req_ready_o` high from C+1; a result pending in DONE is discarded.
- Reset asserted mid-operation: immediate return to reset values, no result produced.

## Configuration
- `CORE_MULDIV_DIV_EN` defined: divider datapath, DIV and FIX states present, behaviour as above.
- Not defined: divider logic removed; divide opcodes follow the multiply path (result 0, `res_valid_o` at T+2); multiply behaviour unchanged.

## Structure
- Shared package `core_muldiv_pkg`: opcode constants (MUL=3'b000, MULH=3'b001, MULHU=3'b010, DIV=3'b100, MOD=3'b101, DIVU=3'b110, MODU=3'b111; bit 2 = divide class, bit 0 = remainder for divides, bit 1 = unsigned for divides), FSM state enum.
- Sub-module `core_div_iter`: one restoring-division step datapath (partial remainder, quotient shift), instantiated only under `CORE_MULDIV_DIV_EN`.

## Test plan
- MUL: r1=0x0000_0007, r0=0xFFFF_FFFD -> res_o=0xFFFF_FFEB at T+2; MULH -> 0xFFFF_FFFF; MULHU -> 0x0000_0006.
- DIV/MOD signed: r1=0xFFFF_FFF9 (-7), r0=2 -> DIV 0xFFFF_FFFD, MOD 0xFFFF_FFFF at T+35; DIVU -> 0x7FFF_FFFC.
- Divide-by-zero: r1=0x1234_5678, r0=0 -> DIV 0xFFFF_FFFF, MOD 0x1234_5678, valid at T+1.
- Overflow: r1=0x8000_0000, r0=0xFFFF_FFFF, DIV -> 0x8000_0000, MOD -> 0.
- Backpressure/flush: hold `res_ready_i`=0 for 5 cycles -> res_o stable, `req_ready_o`=0; flush at DIV iteration 10 -> valid never rises, `req_ready_o`=1 next cycle, next MUL correct.
- Macro off: DIV r1=10, r0=3 -> res_o=0 at T+2; MUL 10*3 -> 30.
